// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/handshake bundle between the multicycle controller and its datapath/buses.
interface multicycle_ctrl_if;
  logic [31:0] inst;
  logic        br_taken;
  logic        ibus_req;
  logic        ibus_ack;
  logic        dbus_req;
  logic        dbus_we;
  logic        dbus_ack;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  npc_op;
  logic [2:0]  sext_op;
  logic        rf_we;
  logic [1:0]  rf_wsel;
  logic [3:0]  alu_ctl;
  logic        halt;
  logic [2:0]  state;
  modport master (
    input  inst, br_taken, ibus_ack, dbus_ack,
    output ibus_req, dbus_req, dbus_we, ir_we, pc_we, npc_op, sext_op,
           rf_we, rf_wsel, alu_ctl, halt, state
  );
  modport slave (
    output inst, br_taken, ibus_ack, dbus_ack,
    input  ibus_req, dbus_req, dbus_we, ir_we, pc_we, npc_op, sext_op,
           rf_we, rf_wsel, alu_ctl, halt, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/writeback sequencer for the multicycle miniCPU.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;
  state_t     r_state, w_next;
  logic       r_live;
  logic [7:0] r_cnt;
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_r, w_i, w_ld, w_st, w_br, w_jal, w_jalr, w_lui, w_legal;
  logic       w_fetch, w_mem, w_req, w_ack, w_tmo;
  logic       w_unused;
  assign w_op    = bus.inst[6:0];
  assign w_f3    = bus.inst[14:12];
  assign w_r     = w_op == 7'b0110011;
  assign w_i     = w_op == 7'b0010011;
  assign w_ld    = w_op == 7'b0000011;
  assign w_st    = w_op == 7'b0100011;
  assign w_br    = w_op == 7'b1100011;
  assign w_jal   = w_op == 7'b1101111;
  assign w_jalr  = w_op == 7'b1100111;
  assign w_lui   = w_op == 7'b0110111;
  assign w_legal = w_r | w_i | w_ld | w_st | w_br | w_jal | w_jalr | w_lui;
  assign w_unused = ^{bus.inst[31], bus.inst[29:15]};
  // r_live holds every request low while in reset and until the first edge after release
  assign w_fetch = r_state == S_FETCH;
  assign w_mem   = r_state == S_MEM;
  assign w_req   = r_live & (w_fetch | w_mem);
  assign w_ack   = w_fetch ? bus.ibus_ack : bus.dbus_ack;
  assign w_tmo   = w_req & ~w_ack & (r_cnt == 8'(MEM_TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_live  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      r_cnt   <= (w_next != r_state) ? 8'd0 : (w_req & ~w_ack) ? r_cnt + 8'd1 : r_cnt;
    end
  end
  always_comb begin
    w_next     = r_state;
    bus.ir_we  = 1'b0;
    bus.pc_we  = 1'b0;
    bus.npc_op = 2'b00;
    bus.rf_we  = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.ir_we = w_req & bus.ibus_ack;
        w_next    = bus.ir_we ? S_DECODE : w_tmo ? S_HALT : S_FETCH;
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        bus.pc_we  = w_br;
        bus.npc_op = {1'b0, w_br & bus.br_taken};
        w_next     = (w_ld | w_st) ? S_MEM : w_br ? S_FETCH : S_WB;
      end
      S_MEM: begin
        bus.pc_we = w_req & bus.dbus_ack & w_st;
        w_next    = (w_req & bus.dbus_ack) ? (w_st ? S_FETCH : S_WB) : w_tmo ? S_HALT : S_MEM;
      end
      S_WB: begin
        bus.rf_we  = bus.inst[11:7] != 5'd0;
        bus.pc_we  = 1'b1;
        bus.npc_op = w_jal ? 2'b10 : w_jalr ? 2'b11 : 2'b00;
        w_next     = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end
  assign bus.ibus_req = w_req & w_fetch;
  assign bus.dbus_req = w_req & w_mem;
  assign bus.dbus_we  = bus.dbus_req & w_st;
  assign bus.halt     = r_state == S_HALT;
  assign bus.state    = r_state;
  assign bus.sext_op  = w_st ? 3'd1 : w_br ? 3'd2 : w_lui ? 3'd3 : w_jal ? 3'd4 : 3'd0;
  assign bus.rf_wsel  = w_ld ? 2'b01 : (w_jal | w_jalr) ? 2'b10 : w_lui ? 2'b11 : 2'b00;
  assign bus.alu_ctl  = (w_ld | w_st | w_jalr) ? 4'b0000 :
                        {bus.inst[30] & (w_r | (w_i & (w_f3 == 3'b101))), w_f3};
endmodule
